clint_burst_splitter: RTL and testbench

- Sits directly upstream of the CLINT AXI slave port, between the SoC crossbar and clint.
- The CLINT handles only single-beat transactions. This block turns every incoming AXI4 burst into a sequence of len=0 transactions.
- It rebuilds burst-level responses: rlast on reads; a single B per burst on writes.
- Read and write paths are independent and each has one downstream transaction outstanding at a time.

---
 rtl/ariane_axi_pkg.sv | 86 ++++++++
 rtl/clint_burst_pkg.sv | 29 ++
 rtl/clint_burst_beat_ctr.sv | 48 ++++
 rtl/clint_burst_splitter.sv | 189 ++++++++++++++++++
 tb/tb_clint_burst_splitter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_axi_pkg.sv
// AXI4 channel and bundle types shared by the Ariane SoC crossbar and its peripherals.
package ariane_axi;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/clint_burst_pkg.sv
// Shared states and helpers for splitting AXI bursts into single-beat CLINT accesses.
package clint_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_e;
  typedef enum logic [2:0] {W_IDLE, W_BEAT, W_RESP, W_BOUT, W_ERR} wr_state_e;

  // EXOKAY on a split beat says nothing about the burst, so it ranks as OKAY.
  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] resp);
    logic [1:0] eff;
    eff = (resp == RESP_EXOKAY) ? RESP_OKAY : resp;
    return (eff > acc) ? eff : acc;
  endfunction

  function automatic ariane_axi::addr_t next_addr(input ariane_axi::addr_t addr,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    if (burst == BURST_INCR) return addr + (ariane_axi::addr_t'(1) << size);
    return addr;
  endfunction

endpackage

// File: rtl/clint_burst_beat_ctr.sv
// Beat counter and address walker for one burst; is_last flags the final beat.
module clint_burst_beat_ctr
  import clint_burst_pkg::*;
(
  input  logic              clk,
  input  logic              ndmreset_n,
  input  logic              load,
  input  logic              advance,
  input  logic [7:0]        len,
  input  ariane_axi::addr_t addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output ariane_axi::addr_t cur_addr,
  output logic              is_last
);

  logic [7:0]        cnt_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  ariane_axi::addr_t addr_q;

  always_ff @(posedge clk or negedge ndmreset_n) begin
    if (!ndmreset_n) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (advance) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      addr_q  <= addr;
      size_q  <= size;
      burst_q <= burst;
    end else if (advance) begin
      addr_q  <= next_addr(addr_q, size_q, burst_q);
    end
  end

  assign cur_addr = addr_q;
  assign is_last  = (cnt_q == len_q);

endmodule

// File: rtl/clint_burst_splitter.sv
// Splits AXI4 bursts into len=0 transactions for the CLINT and rebuilds rlast / a single B.
module clint_burst_splitter
  import clint_burst_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              ndmreset_n,
  input  ariane_axi::req_t  slv_req_i,
  output ariane_axi::resp_t slv_resp_o,
  output ariane_axi::req_t  mst_req_o,
  input  ariane_axi::resp_t mst_resp_i
);

  localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA = '0;

  rd_state_e rd_q;
  wr_state_e wr_q;
  ariane_axi::ar_chan_t rd_ar_q;
  ariane_axi::aw_chan_t wr_aw_q;
  logic                      aw_sent_q, w_sent_q;
  logic [1:0]                resp_acc_q;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [AXI_ID_WIDTH-1:0]   rd_id, wr_id;
  logic                      rd_last, wr_last;
  logic                      rd_load, rd_adv, wr_load, wr_adv;
  logic                      aw_done, w_done;
  logic                      unused_fields;

  assign rd_id = rd_ar_q.id;
  assign wr_id = wr_aw_q.id;

  assign rd_load = (rd_q == R_IDLE) && slv_req_i.ar_valid;
  assign wr_load = (wr_q == W_IDLE) && slv_req_i.aw_valid;
  assign rd_adv  = !rd_last && slv_req_i.r_ready &&
                   ((rd_q == R_ERR) || (rd_q == R_DATA && mst_resp_i.r_valid));
  assign wr_adv  = !wr_last &&
                   ((wr_q == W_RESP && mst_resp_i.b_valid) ||
                    (wr_q == W_ERR && slv_req_i.w_valid));

  assign aw_done = aw_sent_q || mst_resp_i.aw_ready;
  assign w_done  = w_sent_q || (slv_req_i.w_valid && mst_resp_i.w_ready);

  clint_burst_beat_ctr i_rd_ctr (
    .clk        (clk),
    .ndmreset_n (ndmreset_n),
    .load       (rd_load),
    .advance    (rd_adv),
    .len        (slv_req_i.ar.len),
    .addr       (slv_req_i.ar.addr),
    .size       (slv_req_i.ar.size),
    .burst      (slv_req_i.ar.burst),
    .cur_addr   (rd_addr),
    .is_last    (rd_last)
  );

  clint_burst_beat_ctr i_wr_ctr (
    .clk        (clk),
    .ndmreset_n (ndmreset_n),
    .load       (wr_load),
    .advance    (wr_adv),
    .len        (slv_req_i.aw.len),
    .addr       (slv_req_i.aw.addr),
    .size       (slv_req_i.aw.size),
    .burst      (slv_req_i.aw.burst),
    .cur_addr   (wr_addr),
    .is_last    (wr_last)
  );

  // Request fields carry no control meaning until their FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (rd_load) rd_ar_q <= slv_req_i.ar;
    if (wr_load) wr_aw_q <= slv_req_i.aw;
  end

  always_ff @(posedge clk or negedge ndmreset_n) begin
    if (!ndmreset_n) begin
      rd_q <= R_IDLE;
    end else begin
      unique case (rd_q)
        R_IDLE: if (slv_req_i.ar_valid)
                  rd_q <= (slv_req_i.ar.burst == BURST_WRAP) ? R_ERR : R_ADDR;
        R_ADDR: if (mst_resp_i.ar_ready) rd_q <= R_DATA;
        R_DATA: if (mst_resp_i.r_valid && slv_req_i.r_ready)
                  rd_q <= rd_last ? R_IDLE : R_ADDR;
        R_ERR:  if (slv_req_i.r_ready && rd_last) rd_q <= R_IDLE;
        default: rd_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge ndmreset_n) begin
    if (!ndmreset_n) begin
      wr_q       <= W_IDLE;
      aw_sent_q  <= 1'b0;
      w_sent_q   <= 1'b0;
      resp_acc_q <= RESP_OKAY;
    end else begin
      unique case (wr_q)
        W_IDLE: if (slv_req_i.aw_valid) begin
          resp_acc_q <= RESP_OKAY;
          aw_sent_q  <= 1'b0;
          w_sent_q   <= 1'b0;
          wr_q <= (slv_req_i.aw.burst == BURST_WRAP || slv_req_i.aw.atop != '0) ? W_ERR : W_BEAT;
        end
        W_BEAT: begin
          if (aw_done && w_done) begin
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
            wr_q      <= W_RESP;
          end else begin
            aw_sent_q <= aw_done;
            w_sent_q  <= w_done;
          end
        end
        W_RESP: if (mst_resp_i.b_valid) begin
          resp_acc_q <= merge_resp(resp_acc_q, mst_resp_i.b.resp);
          wr_q       <= wr_last ? W_BOUT : W_BEAT;
        end
        W_BOUT: if (slv_req_i.b_ready) wr_q <= W_IDLE;
        W_ERR:  if (slv_req_i.w_valid && wr_last) begin
          resp_acc_q <= RESP_SLVERR;
          wr_q       <= W_BOUT;
        end
        default: wr_q <= W_IDLE;
      endcase
    end
  end

  // Every valid/ready is gated by the reset so nothing handshakes while it is held.
  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;

    mst_req_o.ar       = rd_ar_q;
    mst_req_o.ar.addr  = rd_addr;
    mst_req_o.ar.len   = 8'd0;
    mst_req_o.ar.burst = BURST_INCR;
    mst_req_o.aw       = wr_aw_q;
    mst_req_o.aw.addr  = wr_addr;
    mst_req_o.aw.len   = 8'd0;
    mst_req_o.aw.burst = BURST_INCR;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w.last   = 1'b1;

    unique case (rd_q)
      R_IDLE: slv_resp_o.ar_ready = ndmreset_n;
      R_ADDR: mst_req_o.ar_valid  = ndmreset_n;
      R_DATA: begin
        slv_resp_o.r       = mst_resp_i.r;
        slv_resp_o.r.id    = rd_id;
        slv_resp_o.r.last  = rd_last;
        slv_resp_o.r_valid = ndmreset_n && mst_resp_i.r_valid;
        mst_req_o.r_ready  = ndmreset_n && slv_req_i.r_ready;
      end
      R_ERR: begin
        slv_resp_o.r.id    = rd_id;
        slv_resp_o.r.data  = ERR_DATA;
        slv_resp_o.r.resp  = RESP_SLVERR;
        slv_resp_o.r.last  = rd_last;
        slv_resp_o.r_valid = ndmreset_n;
      end
      default: ;
    endcase

    unique case (wr_q)
      W_IDLE: slv_resp_o.aw_ready = ndmreset_n;
      W_BEAT: begin
        mst_req_o.aw_valid = ndmreset_n && !aw_sent_q;
        mst_req_o.w_valid  = ndmreset_n && !w_sent_q && slv_req_i.w_valid;
        slv_resp_o.w_ready = ndmreset_n && !w_sent_q && mst_resp_i.w_ready;
      end
      W_RESP: mst_req_o.b_ready = ndmreset_n;
      W_BOUT: begin
        slv_resp_o.b_valid = ndmreset_n;
        slv_resp_o.b.id    = wr_id;
        slv_resp_o.b.resp  = resp_acc_q;
      end
      W_ERR:  slv_resp_o.w_ready = ndmreset_n;
      default: ;
    endcase
  end

  assign unused_fields = ^{mst_resp_i.b.id, mst_resp_i.b.user, mst_resp_i.r.last,
                           slv_req_i.w.last};

endmodule

// File: tb/tb_clint_burst_splitter.sv
// Directed bench: burst splitting, error bursts, concurrency, backpressure and reset abort.
module tb_clint_burst_splitter;
  import clint_burst_pkg::*;

  logic clk;
  logic ndmreset_n;
  ariane_axi::req_t  slv_req;
  ariane_axi::resp_t slv_resp;
  ariane_axi::req_t  mst_req;
  ariane_axi::resp_t mst_resp;

  int checks = 0;
  int errors = 0;

  clint_burst_splitter dut (
    .clk        (clk),
    .ndmreset_n (ndmreset_n),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    slv_req    = '0;
    mst_resp   = '0;
    ndmreset_n = 1'b0;
    #2;
    chk("rst_aw_ready", slv_resp.aw_ready, 0);
    chk("rst_ar_ready", slv_resp.ar_ready, 0);
    chk("rst_mst_aw_valid", mst_req.aw_valid, 0);
    chk("rst_mst_ar_valid", mst_req.ar_valid, 0);
    chk("rst_b_valid", slv_resp.b_valid, 0);
    chk("rst_r_valid", slv_resp.r_valid, 0);
    tick(); tick();
    ndmreset_n = 1'b1;
    #1;
    chk("rel_aw_ready", slv_resp.aw_ready, 1);
    chk("rel_ar_ready", slv_resp.ar_ready, 1);

    // INCR read across a 4 KiB line, two beats
    tick();
    slv_req.ar_valid = 1; slv_req.ar.id = 4'd3; slv_req.ar.addr = 64'h0200_BFF8;
    slv_req.ar.len = 8'd1; slv_req.ar.size = 3'd3; slv_req.ar.burst = BURST_INCR;
    #1;
    chk("rd_ar_ready", slv_resp.ar_ready, 1);
    tick();
    slv_req.ar_valid = 0;
    #1;
    chk("rd_mar_valid0", mst_req.ar_valid, 1);
    chk("rd_mar_addr0", mst_req.ar.addr, 64'h0200_BFF8);
    chk("rd_mar_len0", mst_req.ar.len, 0);
    chk("rd_mar_id0", mst_req.ar.id, 3);
    mst_resp.ar_ready = 1;
    tick();
    mst_resp.ar_ready = 0;
    mst_resp.r_valid = 1; mst_resp.r.id = 4'hA; mst_resp.r.data = 64'h1111;
    mst_resp.r.last = 1; mst_resp.r.resp = RESP_OKAY;
    slv_req.r_ready = 1;
    #1;
    chk("rd_mar_drop", mst_req.ar_valid, 0);
    chk("rd_r0_valid", slv_resp.r_valid, 1);
    chk("rd_r0_id", slv_resp.r.id, 3);
    chk("rd_r0_data", slv_resp.r.data, 64'h1111);
    chk("rd_r0_last", slv_resp.r.last, 0);
    chk("rd_r0_mready", mst_req.r_ready, 1);
    tick();
    mst_resp.r_valid = 0;
    #1;
    chk("rd_mar_valid1", mst_req.ar_valid, 1);
    chk("rd_mar_addr1", mst_req.ar.addr, 64'h0200_C000);
    chk("rd_mar_len1", mst_req.ar.len, 0);
    mst_resp.ar_ready = 1;
    tick();
    mst_resp.ar_ready = 0;
    mst_resp.r_valid = 1; mst_resp.r.data = 64'h2222;
    #1;
    chk("rd_r1_id", slv_resp.r.id, 3);
    chk("rd_r1_data", slv_resp.r.data, 64'h2222);
    chk("rd_r1_last", slv_resp.r.last, 1);
    tick();
    mst_resp.r_valid = 0; slv_req.r_ready = 0;
    #1;
    chk("rd_done_ar_ready", slv_resp.ar_ready, 1);
    chk("rd_done_r_valid", slv_resp.r_valid, 0);

    // INCR write, CLINT answers OKAY then SLVERR
    slv_req.aw_valid = 1; slv_req.aw.id = 4'd1; slv_req.aw.addr = 64'h0200_4000;
    slv_req.aw.len = 8'd1; slv_req.aw.size = 3'd3; slv_req.aw.burst = BURST_INCR;
    slv_req.aw.atop = '0;
    tick();
    slv_req.aw_valid = 0;
    slv_req.w_valid = 1; slv_req.w.data = 64'hAAAA; slv_req.w.strb = 8'hFF; slv_req.w.last = 0;
    mst_resp.aw_ready = 1; mst_resp.w_ready = 1;
    #1;
    chk("wr_maw_valid0", mst_req.aw_valid, 1);
    chk("wr_maw_addr0", mst_req.aw.addr, 64'h0200_4000);
    chk("wr_maw_len0", mst_req.aw.len, 0);
    chk("wr_mw_valid0", mst_req.w_valid, 1);
    chk("wr_mw_last0", mst_req.w.last, 1);
    chk("wr_sw_ready0", slv_resp.w_ready, 1);
    tick();
    mst_resp.aw_ready = 0; mst_resp.w_ready = 0;
    mst_resp.b_valid = 1; mst_resp.b.resp = RESP_OKAY;
    slv_req.w.data = 64'hBBBB;
    #1;
    chk("wr_resp_aw_valid", mst_req.aw_valid, 0);
    chk("wr_resp_b_ready", mst_req.b_ready, 1);
    chk("wr_resp_w_ready", slv_resp.w_ready, 0);
    chk("wr_resp_sb_valid", slv_resp.b_valid, 0);
    tick();
    mst_resp.b_valid = 0; mst_resp.aw_ready = 1; mst_resp.w_ready = 1;
    #1;
    chk("wr_maw_addr1", mst_req.aw.addr, 64'h0200_4008);
    chk("wr_mw_data1", mst_req.w.data, 64'hBBBB);
    chk("wr_mw_last1", mst_req.w.last, 1);
    tick();
    slv_req.w_valid = 0; mst_resp.aw_ready = 0; mst_resp.w_ready = 0;
    mst_resp.b_valid = 1; mst_resp.b.resp = RESP_SLVERR;
    #1;
    chk("wr_resp1_sb_valid", slv_resp.b_valid, 0);
    tick();
    mst_resp.b_valid = 0;
    #1;
    chk("wr_b_valid", slv_resp.b_valid, 1);
    chk("wr_b_id", slv_resp.b.id, 1);
    chk("wr_b_resp", slv_resp.b.resp, RESP_SLVERR);
    slv_req.b_ready = 1;
    tick();
    slv_req.b_ready = 0;
    #1;
    chk("wr_done_b_valid", slv_resp.b_valid, 0);
    chk("wr_done_aw_ready", slv_resp.aw_ready, 1);

    // WRAP read answered locally with SLVERR
    slv_req.ar_valid = 1; slv_req.ar.id = 4'd7; slv_req.ar.addr = 64'h0200_0000;
    slv_req.ar.len = 8'd3; slv_req.ar.size = 3'd3; slv_req.ar.burst = BURST_WRAP;
    tick();
    slv_req.ar_valid = 0; slv_req.r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wrap_mar_valid", mst_req.ar_valid, 0);
      chk("wrap_r_valid", slv_resp.r_valid, 1);
      chk("wrap_r_resp", slv_resp.r.resp, RESP_SLVERR);
      chk("wrap_r_data", slv_resp.r.data, 0);
      chk("wrap_r_id", slv_resp.r.id, 7);
      chk("wrap_r_last", slv_resp.r.last, (i == 3) ? 1 : 0);
      tick();
    end
    slv_req.r_ready = 0;
    #1;
    chk("wrap_done_r_valid", slv_resp.r_valid, 0);
    chk("wrap_done_ar_ready", slv_resp.ar_ready, 1);

    // Simultaneous AR(id 2) and AW(id 5)
    slv_req.ar_valid = 1; slv_req.ar.id = 4'd2; slv_req.ar.addr = 64'h0200_0000;
    slv_req.ar.len = 8'd0; slv_req.ar.burst = BURST_INCR;
    slv_req.aw_valid = 1; slv_req.aw.id = 4'd5; slv_req.aw.addr = 64'h0200_0008;
    slv_req.aw.len = 8'd0; slv_req.aw.burst = BURST_INCR;
    #1;
    chk("sim_ar_ready", slv_resp.ar_ready, 1);
    chk("sim_aw_ready", slv_resp.aw_ready, 1);
    tick();
    slv_req.ar_valid = 0; slv_req.aw_valid = 0;
    slv_req.w_valid = 1; slv_req.w.data = 64'hCCCC;
    mst_resp.ar_ready = 1; mst_resp.aw_ready = 1; mst_resp.w_ready = 1;
    #1;
    chk("sim_mar_id", mst_req.ar.id, 2);
    chk("sim_maw_id", mst_req.aw.id, 5);
    chk("sim_maw_addr", mst_req.aw.addr, 64'h0200_0008);
    tick();
    mst_resp.ar_ready = 0; mst_resp.aw_ready = 0; mst_resp.w_ready = 0;
    slv_req.w_valid = 0;
    mst_resp.r_valid = 1; mst_resp.r.id = 4'd9; mst_resp.r.data = 64'h5;
    mst_resp.b_valid = 1; mst_resp.b.id = 4'd9; mst_resp.b.resp = RESP_EXOKAY;
    slv_req.r_ready = 1;
    #1;
    chk("sim_r_id", slv_resp.r.id, 2);
    chk("sim_r_last", slv_resp.r.last, 1);
    chk("sim_b_ready", mst_req.b_ready, 1);
    chk("sim_b_early", slv_resp.b_valid, 0);
    tick();
    mst_resp.r_valid = 0; mst_resp.b_valid = 0; slv_req.r_ready = 0;
    #1;
    chk("sim_b_valid", slv_resp.b_valid, 1);
    chk("sim_b_id", slv_resp.b.id, 5);
    chk("sim_b_resp", slv_resp.b.resp, RESP_OKAY);
    chk("sim_r_done", slv_resp.r_valid, 0);
    slv_req.b_ready = 1;
    tick();
    slv_req.b_ready = 0;

    // AW backpressured three cycles while W goes through at once
    slv_req.aw_valid = 1; slv_req.aw.id = 4'd4; slv_req.aw.addr = 64'h0200_0010;
    slv_req.aw.len = 8'd0;
    tick();
    slv_req.aw_valid = 0;
    slv_req.w_valid = 1; slv_req.w.data = 64'hDDDD;
    mst_resp.w_ready = 1; mst_resp.aw_ready = 0;
    #1;
    chk("bp_aw_valid0", mst_req.aw_valid, 1);
    chk("bp_w_valid0", mst_req.w_valid, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("bp_w_not_repeated", mst_req.w_valid, 0);
      chk("bp_sw_ready", slv_resp.w_ready, 0);
      chk("bp_aw_held", mst_req.aw_valid, 1);
      chk("bp_no_b_ready", mst_req.b_ready, 0);
    end
    mst_resp.aw_ready = 1;
    tick();
    slv_req.w_valid = 0; mst_resp.aw_ready = 0; mst_resp.w_ready = 0;
    mst_resp.b_valid = 1; mst_resp.b.resp = RESP_OKAY;
    #1;
    chk("bp_aw_once", mst_req.aw_valid, 0);
    chk("bp_b_ready", mst_req.b_ready, 1);
    tick();
    mst_resp.b_valid = 0;
    #1;
    chk("bp_b_valid", slv_resp.b_valid, 1);
    chk("bp_b_id", slv_resp.b.id, 4);
    slv_req.b_ready = 1;
    tick();
    slv_req.b_ready = 0;

    // Reset pulse during beat 1 of a four-beat write
    slv_req.aw_valid = 1; slv_req.aw.id = 4'd6; slv_req.aw.addr = 64'h0200_4000;
    slv_req.aw.len = 8'd3;
    tick();
    slv_req.aw_valid = 0; slv_req.w_valid = 1;
    #1;
    chk("rb_aw_valid", mst_req.aw_valid, 1);
    ndmreset_n = 1'b0;
    #1;
    chk("rb_rst_aw_valid", mst_req.aw_valid, 0);
    chk("rb_rst_w_valid", mst_req.w_valid, 0);
    chk("rb_rst_w_ready", slv_resp.w_ready, 0);
    chk("rb_rst_aw_ready", slv_resp.aw_ready, 0);
    chk("rb_rst_b_valid", slv_resp.b_valid, 0);
    slv_req.w_valid = 0;
    tick(); tick();
    ndmreset_n = 1'b1;
    #1;
    chk("rb_rel_aw_ready", slv_resp.aw_ready, 1);
    chk("rb_rel_ar_ready", slv_resp.ar_ready, 1);
    mst_resp.aw_ready = 1; mst_resp.w_ready = 1; slv_req.b_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rb_no_b", slv_resp.b_valid, 0);
      chk("rb_no_aw", mst_req.aw_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
